dmem_write_buffer: RTL and testbench

Line-granular write buffer placed between the data cache and the `Memory` data port. It absorbs dirty-line evictions from the cache and drains them to memory in the background using the `d_readM`/`d_writeM`/`d_doneM` protocol. Line fills from the cache are given priority over draining and are served from the buffer when the line is still pending (store-to-load forwarding). From the memory's point of view it is the sole initiator of the data port.

---
 rtl/dmem_write_buffer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_dmem_write_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
//   Line-granular write buffer sitting between the data cache and the memory
//   data port. Evicted dirty lines are queued in a small circular FIFO and
//   drained to memory in the background; line fills from the cache are
//   served either from the buffer (forwarding) or from memory.
//
// Configuration macro: WB_FORWARD_EN
//   defined   : fills that hit a buffered line are answered from the buffer,
//               and misses are issued to memory ahead of any pending drain.
//   undefined : no forwarding; a fill goes to memory only once the buffer is
//               empty, so memory always holds the newest copy of the line.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   wb_write/wb_address/
//   wb_data, wb_full        eviction push side (push dropped while full)
//   rd_req/rd_address,
//   rd_data/rd_valid        line-fill request side (rd_valid is a 1-cycle pulse)
//   d_readM/d_writeM/
//   d_address/d_data        memory request side (d_data driven only on writes)
//   d_readyM, d_input_readyM,
//   d_doneM, d_written_address  memory responses
//   empty                   buffer holds no lines
module dmem_write_buffer #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wb_write,
  input  logic [WORD_SIZE-1:0]            wb_address,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] wb_data,
  output logic                            wb_full,
  input  logic                            rd_req,
  input  logic [WORD_SIZE-1:0]            rd_address,
  output logic [LINE_WORDS*WORD_SIZE-1:0] rd_data,
  output logic                            rd_valid,
  output logic                            d_readM,
  output logic                            d_writeM,
  output logic [WORD_SIZE-1:0]            d_address,
  inout  wire  [LINE_WORDS*WORD_SIZE-1:0] d_data,
  input  logic                            d_readyM,
  input  logic                            d_input_readyM,
  input  logic                            d_doneM,
  input  logic [WORD_SIZE-1:0]            d_written_address,
  output logic                            empty
);

  localparam int LINE_BITS = LINE_WORDS * WORD_SIZE;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ADDR_LSB  = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [PTR_W-1:0]     head_r;
  logic [PTR_W-1:0]     tail_r;
  logic [CNT_W-1:0]     count_r;
  logic [WORD_SIZE-1:0] addr_mem_r [DEPTH];
  logic [LINE_BITS-1:0] line_mem_r [DEPTH];
  logic [LINE_BITS-1:0] wdata_r;

  logic push_s;
  logic pop_s;
  logic issue_rd_s;
  logic issue_wr_s;
  logic rd_done_s;
  logic fwd_s;
  logic rd_pend_s;

  assign wb_full = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == {CNT_W{1'b0}});
  assign push_s  = wb_write && !wb_full;
  // While rd_valid is high the requester is still holding rd_req for the
  // request that just completed; it must not start a second one.
  assign rd_pend_s = rd_req && !rd_valid;

  assign d_data = d_writeM ? wdata_r : {LINE_BITS{1'bz}};

`ifdef WB_FORWARD_EN
  logic                 hit_s;
  logic [LINE_BITS-1:0] hit_data_s;
  logic [PTR_W-1:0]     scan_idx_s;

  // Forward lookup: scan oldest to youngest so the youngest match wins, then
  // let the line being pushed this cycle override everything.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = {LINE_BITS{1'b0}};
    scan_idx_s = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = head_r + PTR_W'(i);
      if ((CNT_W'(i) < count_r) &&
          (addr_mem_r[scan_idx_s][WORD_SIZE-1:ADDR_LSB] == rd_address[WORD_SIZE-1:ADDR_LSB])) begin
        hit_s      = 1'b1;
        hit_data_s = line_mem_r[scan_idx_s];
      end else begin
        hit_s      = hit_s;
      end
    end
    if (push_s && (wb_address[WORD_SIZE-1:ADDR_LSB] == rd_address[WORD_SIZE-1:ADDR_LSB])) begin
      hit_s      = 1'b1;
      hit_data_s = wb_data;
    end else begin
      hit_s      = hit_s;
    end
  end
`endif

  // Next-state and transaction control decode.
  always_comb begin
    state_nxt_s = state_r;
    issue_rd_s  = 1'b0;
    issue_wr_s  = 1'b0;
    pop_s       = 1'b0;
    rd_done_s   = 1'b0;
    fwd_s       = 1'b0;
    case (state_r)
      IDLE: begin
`ifdef WB_FORWARD_EN
        if (rd_pend_s && hit_s) begin
          fwd_s = 1'b1;
        end else if (rd_pend_s && d_input_readyM) begin
          issue_rd_s  = 1'b1;
          state_nxt_s = RD_WAIT;
        end else if (!rd_pend_s && !empty && d_input_readyM) begin
          issue_wr_s  = 1'b1;
          state_nxt_s = WR_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
`else
        // Drain first: a fill only goes out once every buffered line has
        // reached memory.
        if (rd_pend_s && empty && d_input_readyM) begin
          issue_rd_s  = 1'b1;
          state_nxt_s = RD_WAIT;
        end else if (!empty && d_input_readyM) begin
          issue_wr_s  = 1'b1;
          state_nxt_s = WR_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
`endif
      end
      RD_WAIT: begin
        if (d_readyM) begin
          rd_done_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      WR_WAIT: begin
`ifdef WB_FORWARD_EN
        // The line being drained is still counted, so it can be forwarded.
        if (rd_pend_s && hit_s) begin
          fwd_s = 1'b1;
        end else begin
          fwd_s = 1'b0;
        end
`endif
        if (d_doneM && (d_written_address == addr_mem_r[head_r])) begin
          pop_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR_WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[tail_r] <= wb_address;
      line_mem_r[tail_r] <= wb_data;
    end
  end

  // Registered memory-port requests; held until the matching response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_readM   <= 1'b0;
      d_writeM  <= 1'b0;
      d_address <= {WORD_SIZE{1'b0}};
      wdata_r   <= {LINE_BITS{1'b0}};
    end else begin
      if (issue_rd_s) begin
        d_readM   <= 1'b1;
        d_address <= rd_address;
      end else if (rd_done_s) begin
        d_readM   <= 1'b0;
      end
      if (issue_wr_s) begin
        d_writeM  <= 1'b1;
        d_address <= addr_mem_r[head_r];
        wdata_r   <= line_mem_r[head_r];
      end else if (pop_s) begin
        d_writeM  <= 1'b0;
      end
    end
  end

  // Fill response: one-cycle valid pulse with the forwarded or fetched line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= {LINE_BITS{1'b0}};
    end else begin
      rd_valid <= fwd_s || rd_done_s;
`ifdef WB_FORWARD_EN
      if (fwd_s) begin
        rd_data <= hit_data_s;
      end else if (rd_done_s) begin
        rd_data <= d_data;
      end
`else
      if (rd_done_s) begin
        rd_data <= d_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer (default parameters: 16-bit words,
// 4-word lines, 4 entries). The bench plays the memory side by hand; the
// forwarding scenarios follow whichever WB_FORWARD_EN build is compiled.
module tb_dmem_write_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_write;
  logic [15:0] wb_address;
  logic [63:0] wb_data;
  wire         wb_full;
  logic        rd_req;
  logic [15:0] rd_address;
  wire  [63:0] rd_data;
  wire         rd_valid;
  wire         d_readM;
  wire         d_writeM;
  wire  [15:0] d_address;
  wire  [63:0] d_data;
  logic        d_readyM;
  logic        d_input_readyM;
  logic        d_doneM;
  logic [15:0] d_written_address;
  wire         empty;

  logic [63:0] mem_q;
  logic        mem_drv;
  assign d_data = mem_drv ? mem_q : {64{1'bz}};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_write_buffer #(.WORD_SIZE(16), .LINE_WORDS(4), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_write(wb_write), .wb_address(wb_address), .wb_data(wb_data), .wb_full(wb_full),
    .rd_req(rd_req), .rd_address(rd_address), .rd_data(rd_data), .rd_valid(rd_valid),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data),
    .d_readyM(d_readyM), .d_input_readyM(d_input_readyM), .d_doneM(d_doneM),
    .d_written_address(d_written_address), .empty(empty)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [63:0] d);
    wb_write   = 1'b1;
    wb_address = a;
    wb_data    = d;
    step();
    wb_write   = 1'b0;
  endtask

  // Wait for the next write, check it, then complete it (optionally after a
  // stray completion carrying the wrong address).
  task automatic serve_write(input logic [15:0] a, input logic [63:0] d, input logic bad_first);
    int n = 0;
    while (d_writeM !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk1("wr_issue", d_writeM, 1'b1);
    chk1("wr_no_read", d_readM, 1'b0);
    chk16("wr_addr", d_address, a);
    chk64("wr_data", d_data, d);
    step();
    step();
    chk16("wr_hold_addr", d_address, a);
    if (bad_first) begin
      d_doneM           = 1'b1;
      d_written_address = a ^ 16'h8000;
      step();
      d_doneM           = 1'b0;
      chk1("wr_bad_done_ignored", d_writeM, 1'b1);
    end
    d_doneM           = 1'b1;
    d_written_address = a;
    step();
    d_doneM           = 1'b0;
    chk1("wr_popped", d_writeM, 1'b0);
  endtask

  // Wait for a fill request, answer it after lat cycles, check the response.
  task automatic serve_read(input logic [15:0] a, input logic [63:0] c, input int lat);
    int n = 0;
    while (d_readM !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk1("rd_issue", d_readM, 1'b1);
    chk1("rd_no_write", d_writeM, 1'b0);
    chk16("rd_addr", d_address, a);
    repeat (lat) step();
    chk1("rd_hold", d_readM, 1'b1);
    mem_q    = c;
    mem_drv  = 1'b1;
    d_readyM = 1'b1;
    step();
    d_readyM = 1'b0;
    mem_drv  = 1'b0;
    chk1("rd_valid_pulse", rd_valid, 1'b1);
    chk64("rd_data", rd_data, c);
    chk1("rd_dropped", d_readM, 1'b0);
    rd_req = 1'b0;
    step();
    chk1("rd_valid_end", rd_valid, 1'b0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; wb_write = 1'b0; wb_address = 16'h0000; wb_data = 64'h0;
    rd_req = 1'b0; rd_address = 16'h0000; d_readyM = 1'b0; d_input_readyM = 1'b0;
    d_doneM = 1'b0; d_written_address = 16'h0000; mem_q = 64'h0; mem_drv = 1'b0;

    // Reset values
    step(); step();
    chk1("rst_readM", d_readM, 1'b0);
    chk1("rst_writeM", d_writeM, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", wb_full, 1'b0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk16("rst_d_address", d_address, 16'h0000);
    chk64("rst_rd_data", rd_data, 64'h0);
    reset_n = 1'b1;
    d_input_readyM = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("idle_no_read", d_readM, 1'b0);
      chk1("idle_no_write", d_writeM, 1'b0);
    end
    chk1("idle_empty", empty, 1'b1);
    // Bus must be released: the bench's value comes through unaltered.
    mem_q = 64'hA5A5_5A5A_0F0F_F0F0; mem_drv = 1'b1;
    #1 chk64("bus_released", d_data, 64'hA5A5_5A5A_0F0F_F0F0);
    mem_drv = 1'b0;

    // Fill to full, drop a fifth push, drain in order
    d_input_readyM = 1'b0;
    push(16'h0010, 64'h1111_0000_0000_0010);
    chk1("one_not_empty", empty, 1'b0);
    push(16'h0020, 64'h2222_0000_0000_0020);
    push(16'h0030, 64'h3333_0000_0000_0030);
    chk1("three_not_full", wb_full, 1'b0);
    push(16'h0040, 64'h4444_0000_0000_0040);
    chk1("four_full", wb_full, 1'b1);
    push(16'h0050, 64'h5555_0000_0000_0050);
    chk1("fifth_still_full", wb_full, 1'b1);
    d_input_readyM = 1'b1;
    serve_write(16'h0010, 64'h1111_0000_0000_0010, 1'b1);
    chk1("full_cleared", wb_full, 1'b0);
    serve_write(16'h0020, 64'h2222_0000_0000_0020, 1'b0);
    serve_write(16'h0030, 64'h3333_0000_0000_0030, 1'b0);
    serve_write(16'h0040, 64'h4444_0000_0000_0040, 1'b0);
    repeat (5) step();
    chk1("fifth_dropped", d_writeM, 1'b0);
    chk1("drained_empty", empty, 1'b1);

    // Fill miss with two lines buffered
    d_input_readyM = 1'b0;
    push(16'h0100, 64'hD0D0_0000_0000_0100);
    push(16'h0110, 64'hD1D1_0000_0000_0110);
    rd_req = 1'b1; rd_address = 16'h0080;
    d_input_readyM = 1'b1;
`ifdef WB_FORWARD_EN
    serve_read(16'h0080, 64'hC0C0_C1C1_C2C2_C3C3, 3);
    serve_write(16'h0100, 64'hD0D0_0000_0000_0100, 1'b0);
    serve_write(16'h0110, 64'hD1D1_0000_0000_0110, 1'b0);
`else
    serve_write(16'h0100, 64'hD0D0_0000_0000_0100, 1'b0);
    serve_write(16'h0110, 64'hD1D1_0000_0000_0110, 1'b0);
    serve_read(16'h0080, 64'hC0C0_C1C1_C2C2_C3C3, 3);
`endif
    chk1("miss_empty", empty, 1'b1);

    // Same line pushed twice, then filled (line-offset address bits set)
    d_input_readyM = 1'b0;
    push(16'h0020, 64'hAAAA_AAAA_AAAA_AAAA);
    push(16'h0020, 64'hBBBB_BBBB_BBBB_BBBB);
    rd_req = 1'b1; rd_address = 16'h0023;
`ifdef WB_FORWARD_EN
    step();
    chk1("fwd_valid", rd_valid, 1'b1);
    chk64("fwd_data_youngest", rd_data, 64'hBBBB_BBBB_BBBB_BBBB);
    chk1("fwd_no_read", d_readM, 1'b0);
    rd_req = 1'b0;
    step();
    chk1("fwd_valid_end", rd_valid, 1'b0);
    d_input_readyM = 1'b1;
    serve_write(16'h0020, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    serve_write(16'h0020, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
`else
    d_input_readyM = 1'b1;
    serve_write(16'h0020, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    serve_write(16'h0020, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
    serve_read(16'h0023, 64'hBBBB_BBBB_BBBB_BBBB, 1);
`endif

    // Push while full on the same cycle as a pop: push dropped
    d_input_readyM = 1'b0;
    push(16'h0200, 64'h0200_0200_0200_0200);
    push(16'h0210, 64'h0210_0210_0210_0210);
    push(16'h0220, 64'h0220_0220_0220_0220);
    push(16'h0230, 64'h0230_0230_0230_0230);
    chk1("wrap_full", wb_full, 1'b1);
    d_input_readyM = 1'b1;
    n = 0;
    while (d_writeM !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk16("sim_head_addr", d_address, 16'h0200);
    step();
    d_doneM = 1'b1; d_written_address = 16'h0200;
    wb_write = 1'b1; wb_address = 16'h0240; wb_data = 64'h0240_0240_0240_0240;
    step();
    d_doneM = 1'b0; wb_write = 1'b0;
    chk1("sim_push_dropped", wb_full, 1'b0);
    push(16'h0250, 64'h0250_0250_0250_0250);
    chk1("sim_refull", wb_full, 1'b1);
    serve_write(16'h0210, 64'h0210_0210_0210_0210, 1'b0);
    serve_write(16'h0220, 64'h0220_0220_0220_0220, 1'b0);
    serve_write(16'h0230, 64'h0230_0230_0230_0230, 1'b0);
    serve_write(16'h0250, 64'h0250_0250_0250_0250, 1'b0);
    for (int i = 0; i < 6; i++) begin
      push(16'h0300 + 16'(i * 16), {4{16'h0300 + 16'(i * 16)}});
      serve_write(16'h0300 + 16'(i * 16), {4{16'h0300 + 16'(i * 16)}}, 1'b0);
    end
    repeat (3) step();
    chk1("wrap_empty", empty, 1'b1);
    chk1("wrap_no_write", d_writeM, 1'b0);

    // Asynchronous reset in the middle of a write
    d_input_readyM = 1'b0;
    push(16'h0400, 64'h0400_0400_0400_0400);
    d_input_readyM = 1'b1;
    n = 0;
    while (d_writeM !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk1("mid_wr_started", d_writeM, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("async_writeM", d_writeM, 1'b0);
    chk1("async_empty", empty, 1'b1);
    chk1("async_full", wb_full, 1'b0);
    chk16("async_addr", d_address, 16'h0000);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk1("post_rst_no_write", d_writeM, 1'b0);
    chk1("post_rst_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
